// File: rtl/dac_sample_sequencer.sv
// Sample-rate scheduler feeding the dac modulator.
// FIFO-buffered stream, one sample per period, pop-free mute ramp.
module dac_sample_sequencer #(
  parameter int          CLK_DIV    = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RAMP_STEP  = 16'h0400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        enable,
  input  logic                        mute,
  output logic [15:0]                 dac_din,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [15:0]   MID     = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RAMP,
    MUTED
  } state_t;

  state_t state;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          empty;
  logic [15:0]   head;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_wrap;
  logic          tick;

  logic [16:0]   sub;
  logic [16:0]   add;
  logic [15:0]   ramp_next;
  logic          ramp_done;

  assign s_ready    = (count != FULL);
  assign fifo_level = count;
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign push       = s_valid && s_ready;

  // sample_tick is registered high exactly while cnt sits at its top
  assign tick = sample_tick;

  // Pops only at a tick of a running state; a push in the tick
  // cycle cannot be popped since empty comes from the registered count.
  assign pop = enable && tick && !empty && (state != IDLE);

  assign cnt_wrap = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);

  // Ramp toward midscale in 17 bits, clamping exactly at MID
  always_comb begin
    sub       = {1'b0, dac_din} - {1'b0, RAMP_STEP};
    add       = {1'b0, dac_din} + {1'b0, RAMP_STEP};
    ramp_next = MID;
    if (dac_din > MID) begin
      if (!sub[16] && (sub[15:0] > MID)) begin
        ramp_next = sub[15:0];
      end
    end else begin
      if (add < {1'b0, MID}) begin
        ramp_next = add[15:0];
      end
    end
  end

  assign ramp_done = (ramp_next == MID);

  // FIFO storage; stale entries are harmless after a reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM with period counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dac_din     <= MID;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      cnt         <= '0;
      dac_din     <= MID;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_wrap;
      sample_tick <= (cnt_wrap == CNT_MAX);
      underrun    <= 1'b0;
      unique case (state)
        IDLE: begin
          state       <= PLAY;
          cnt         <= '0;
          sample_tick <= 1'b0;
          dac_din     <= MID;
        end
        PLAY: begin
          if (tick) begin
            if (!empty) begin
              dac_din <= head;
            end else begin
              underrun <= 1'b1;
            end
          end
          if (mute) begin
            state <= RAMP;
          end
        end
        RAMP: begin
          if (tick) begin
            dac_din <= ramp_next;
            if (ramp_done) begin
              state <= mute ? MUTED : PLAY;
            end
          end else if (dac_din == MID) begin
            state <= mute ? MUTED : PLAY;
          end
        end
        MUTED: begin
          dac_din <= MID;
          if (!mute) begin
            state <= PLAY;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dac_sample_sequencer.md
# dac_sample_sequencer

Sample-rate scheduler in front of the `dac` modulator. It accepts 16-bit unsigned samples over a valid/ready stream into a small FIFO. It presents one sample per sample period on `dac_din`, and ramps the output to midscale on mute to avoid pops. It drives `din` of `dac` directly and runs on the same clock.

## Interface
- `CLK_DIV`, 256: clock cycles per sample period; ≥ 2.
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥ 2.
- `RAMP_STEP`, 16'h0400: per-tick step of the mute ramp; nonzero.

- `clk`  in  1  system clock, shared with `dac`.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `s_data`  in  16  unsigned sample, 16'h8000 = midscale.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO can accept; equals !full.
- `enable`  in  1  run sample clock; low = idle.
- `mute`  in  1  request ramp to midscale.
- `dac_din`  out  16  registered sample to `dac.din`.
- `sample_tick`  out  1  one-cycle pulse at each sample boundary.
- `underrun`  out  1  one-cycle pulse when a tick finds the FIFO empty in PLAY.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO:
  - A push occurs on `s_valid && s_ready`. `s_ready = (fifo_level != FIFO_DEPTH)`.
  - Push and pop in the same cycle leave the level unchanged.
  - When full, a push is refused even if a pop happens in that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Tick counter: `cnt` counts 0..CLK_DIV-1 while `enable` is high and wraps to 0. `sample_tick` is high in the cycle where `cnt == CLK_DIV-1`.
- States:
  - IDLE: `dac_din` = 16'h8000; `cnt` held at 0; FIFO accepts pushes, no pops. Goes to PLAY when `enable` is high.
  - PLAY: on tick, if the FIFO is non-empty, pop and load the head into `dac_din`. If it is empty, hold `dac_din` and pulse `underrun`. Goes to RAMP when `mute` is high.
  - RAMP: on tick, pop and discard one sample if available, without pulsing `underrun`. `dac_din` moves toward 16'h8000 by RAMP_STEP and clamps exactly at 16'h8000, with no overshoot or wrap. Goes to MUTED when `dac_din == 16'h8000`.
  - MUTED: `dac_din` = 16'h8000; on tick, pop and discard one sample if available. Goes to PLAY when `mute` is low; the next tick loads a fresh sample.
  - RAMP with `mute` low: continues the ramp to midscale, then goes straight to PLAY.
- `enable` low in any state: next cycle the block is in IDLE, `dac_din` = 16'h8000, `cnt` = 0. FIFO contents are kept.
- Ramp arithmetic:
  - Computed in 17 bits.
  - Above midscale: `max(dac_din - RAMP_STEP, 16'h8000)`.
  - Below midscale: `min(dac_din + RAMP_STEP, 16'h8000)`.

## Timing
- All outputs are registered except `s_ready` and `fifo_level`, which are combinational from registered state.
- Reset values: `dac_din` = 16'h8000, `sample_tick` = 0, `underrun` = 0, `fifo_level` = 0, `s_ready` = 1; state IDLE, `cnt` = 0, FIFO pointers 0.
- First tick after `enable` rises: `enable` high at edge k gives state PLAY at k+1. `cnt` counts from k+1, and the first `sample_tick` is high in cycle k+CLK_DIV.
- `dac_din` updates at the clock edge ending the tick cycle, so `sample_tick` precedes the new `dac_din` by one cycle. `underrun` is coincident with `dac_din` (the hold), one cycle after the tick.
- A sample pushed in the tick cycle itself is not visible to that tick's pop.
- `mute` is sampled each cycle; a transition takes effect from the next tick.
- `rst` mid-operation: the next cycle equals the reset state. FIFO contents are discarded and any in-flight push is dropped.

## Test plan
- Reset values: CLK_DIV=8. Assert `rst` 2 cycles, then check every output against its reset value.
- Basic playback: CLK_DIV=8. Push 16'h1000 and 16'hF000, raise `enable`. Ticks fire every 8 cycles; `dac_din` becomes 16'h1000, then 16'hF000. The third tick pulses `underrun` and holds 16'hF000.
- FIFO full: push with `enable` low. `s_ready` drops after 4 pushes and `fifo_level` = 4. A 5th push with `s_valid` held is refused and the data is not lost from the source.
- Mute ramp: `dac_din` = 16'hF000, RAMP_STEP = 16'h4000, assert `mute`. Successive ticks give 16'hB000, then 16'h8000 (clamped), then MUTED. Deassert `mute`; the next tick loads the next FIFO sample.
- Ramp from below: `dac_din` = 16'h1000, RAMP_STEP = 16'h4000. Ticks give 16'h5000, then 16'h8000; no overshoot past midscale.
- Disable and reset mid-run: drop `enable` mid-period; `dac_din` = 16'h8000 next cycle and FIFO contents are kept. Pulse `rst` with 3 samples queued; `fifo_level` = 0 next cycle.
